decod_47: RTL and testbench

//   BCD-to-7-segment decoder for the microwave timer display digits.

---
 rtl/decod_47.sv | 56 +++++
 tb/tb_decod_47.sv | 87 ++++++++
 2 files changed

// File: rtl/decod_47.sv
// BCD-to-7-segment decoder for one microwave timer display digit.
// Registered output with one cycle of latency and an optional common-anode inversion.
module decod_47 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       blank,
    output logic [6:0] segs
);

    // Active-high {a..g} patterns; non-BCD codes show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h7E;
            4'd1:    pat = 7'h30;
            4'd2:    pat = 7'h6D;
            4'd3:    pat = 7'h79;
            4'd4:    pat = 7'h33;
            4'd5:    pat = 7'h5B;
            4'd6:    pat = 7'h5F;
            4'd7:    pat = 7'h70;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h7B;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [6:0] seg_p0;
    logic [6:0] seg_p1;

    // Stage 0: combinational decode with blanking.
    always_comb begin
        seg_p0 = 7'h00;
        if (!blank)
            seg_p0 = seg_decode({A, B, C, D});
    end

    // Stage 1: output register; reset drives the off pattern.
    always_ff @(posedge clk) begin
        if (rst)
            seg_p1 <= 7'h00;
        else
            seg_p1 <= seg_p0;
    end

    // Polarity is applied after the register so reset and blank invert too.
    assign segs = ACTIVE_LOW ? ~seg_p1 : seg_p1;

endmodule

// File: tb/tb_decod_47.sv
// Directed testbench for decod_47, checking both output polarities side by side.
module tb_decod_47;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] segs_hi;
    logic [6:0] segs_lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] table_hi [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    decod_47 #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
        .blank(blank), .segs(segs_hi)
    );

    decod_47 #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
        .blank(blank), .segs(segs_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 7'h%02h expected 7'h%02h", tag, got, exp);
        end
    endtask

    task automatic set_code(input logic [3:0] code);
        {A, B, C, D} = code;
    endtask

    // Apply inputs, take one edge, then check both polarities just after it.
    task automatic step(input string tag, input logic [3:0] code, input logic bl,
                        input logic r, input logic [6:0] exp_hi);
        set_code(code);
        blank = bl;
        rst   = r;
        @(posedge clk);
        #1;
        check({tag, "_hi"}, segs_hi, exp_hi);
        check({tag, "_lo"}, segs_lo, ~exp_hi);
    endtask

    initial begin
        #1;
        // Reset held two cycles with code 8 on the inputs.
        step("rst0", 4'b1000, 1'b0, 1'b1, 7'h00);
        step("rst1", 4'b1000, 1'b0, 1'b1, 7'h00);
        step("rst_release", 4'b1000, 1'b0, 1'b0, 7'h7F);

        for (int i = 0; i < 10; i++)
            step($sformatf("sweep%0d", i), 4'(i), 1'b0, 1'b0, table_hi[i]);

        for (int i = 10; i < 16; i++)
            step($sformatf("invalid%0d", i), 4'(i), 1'b0, 1'b0, 7'h00);
        step("after_invalid9", 4'b1001, 1'b0, 1'b0, 7'h7B);

        step("blank8", 4'b1000, 1'b1, 1'b0, 7'h00);
        step("unblank8", 4'b1000, 1'b0, 1'b0, 7'h7F);
        step("blank0", 4'b0000, 1'b1, 1'b0, 7'h00);

        // Code 0 with inverted polarity must read 7'h01.
        step("pol0", 4'b0000, 1'b0, 1'b0, 7'h7E);
        check("pol0_lo_explicit", segs_lo, 7'h01);

        step("pre3", 4'b0011, 1'b0, 1'b0, 7'h79);
        step("mid_rst3", 4'b0011, 1'b0, 1'b1, 7'h00);
        step("post_rst3", 4'b0011, 1'b0, 1'b0, 7'h79);

        // Reset overrides blank and data together.
        step("rst_blank", 4'b0101, 1'b1, 1'b1, 7'h00);
        step("resume5", 4'b0101, 1'b0, 1'b0, 7'h5B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
